// File: rtl/fa_self_checker.sv
// Self-checking sweep engine for a 1-bit full adder: applies all eight
// {a,b,cin} vectors, samples sum/cout after a settle window and reports a verdict.
module fa_self_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       cin,
    input  logic       sum,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned VEC_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [VEC_N-1:0]   fail_nxt;
    logic               pass_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               exp_sum_c;
    logic               exp_cout_c;
    logic               mismatch_c;

    // Stimulus comes straight from the index register, so it only moves on a clock edge.
    assign {a, b, cin} = idx;

    // Golden full-adder reference for the current vector.
    assign exp_sum_c  = ^idx;
    assign exp_cout_c = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    assign mismatch_c = (sum != exp_sum_c) || (cout != exp_cout_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
            pass      <= pass_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                    pass_nxt  = 1'b0;
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES);
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_nxt       = err_count + ERR_W'(1);
                    fail_nxt[idx] = 1'b1;
                end
                // Verdict is latched on entry to DONE so it is valid alongside the done pulse.
                if (idx == IDX_W'(VEC_N - 1)) begin
                    pass_nxt  = (err_nxt == '0);
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES);
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == SETTLE) || (state_nxt == CHECK);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_fa_self_checker.sv
// Scoreboard bench for fa_self_checker: two instances (SETTLE_CYCLES 1 and 3)
// driving behavioural adders with selectable faults.
module tb_fa_self_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pass;
        logic [3:0]  err;
        logic [7:0]  fail;
        int unsigned at;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   errors = 0;
    int   checks = 0;
    int   ndone1 = 0;
    int   ndone3 = 0;

    // DUT 1: SETTLE_CYCLES = 1
    logic rst1, start1, a1, b1, cin1, sum1, cout1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] fail1;
    int   mode1;
    // DUT 3: SETTLE_CYCLES = 3
    logic rst3, start3, a3, b3, cin3, sum3, cout3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [7:0] fail3;
    int   mode3;

    // Adder models: mode 0 golden, 1 sum stuck-at-0, 2 cout inverted.
    assign sum1  = (mode1 == 1) ? 1'b0 : (a1 ^ b1 ^ cin1);
    assign cout1 = ((a1 & b1) | (a1 & cin1) | (b1 & cin1)) ^ (mode1 == 2);
    assign sum3  = (mode3 == 1) ? 1'b0 : (a3 ^ b3 ^ cin3);
    assign cout3 = ((a3 & b3) | (a3 & cin3) | (b3 & cin3)) ^ (mode3 == 2);

    fa_self_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    fa_self_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .sum(sum3), .cout(cout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fail3)
    );

    logic       sel;
    logic [2:0] vec_s;
    logic       busy_s, done_s, pass_s;
    logic [3:0] err_s;
    logic [7:0] fail_s;
    assign vec_s  = sel ? {a3, b3, cin3} : {a1, b1, cin1};
    assign busy_s = sel ? busy3 : busy1;
    assign done_s = sel ? done3 : done1;
    assign pass_s = sel ? pass3 : pass1;
    assign err_s  = sel ? err3  : err1;
    assign fail_s = sel ? fail3 : fail1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop an expectation whenever a done pulse appears.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            ndone1++;
            if (q1.size() == 0) begin
                chk("unexpected_done1", 32'(1), 32'(0));
            end else begin
                e = q1.pop_front();
                chk("pass1",    32'(pass1), 32'(e.pass));
                chk("err1",     32'(err1),  32'(e.err));
                chk("fail1",    32'(fail1), 32'(e.fail));
                chk("latency1", cyc,        e.at);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3 === 1'b1) begin
            ndone3++;
            if (q3.size() == 0) begin
                chk("unexpected_done3", 32'(1), 32'(0));
            end else begin
                e = q3.pop_front();
                chk("pass3",    32'(pass3), 32'(e.pass));
                chk("err3",     32'(err3),  32'(e.err));
                chk("fail3",    32'(fail3), 32'(e.fail));
                chk("latency3", cyc,        e.at);
            end
        end
    end

    // One full sweep; checks per-cycle vector/busy, done pulse width and verdict hold.
    task automatic run(input bit s3, input int m, input logic ep, input logic [3:0] ee,
                       input logic [7:0] ef, input bit hold);
        int          p;
        int unsigned e0;
        bit          seen;
        exp_t        x;
        p   = s3 ? 4 : 2;
        sel = s3;
        @(negedge clk);
        if (s3) begin mode3 = m; start3 = 1'b1; end
        else    begin mode1 = m; start1 = 1'b1; end
        e0 = cyc + 1;
        x.pass = ep; x.err = ee; x.fail = ef; x.at = e0 + 32'(8 * p);
        if (s3) q3.push_back(x); else q1.push_back(x);
        for (int k = 0; k < 8 * p; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) begin start1 = 1'b0; start3 = 1'b0; end
            chk("vec",  32'(vec_s),  32'(k / p));
            chk("busy", 32'(busy_s), 32'(1));
        end
        seen = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(negedge clk);
            seen = done_s;
        end
        chk("done_seen", 32'(seen), 32'(1));
        if (!seen) begin
            if (s3) q3.delete(); else q1.delete();
        end
        start1 = 1'b0;
        start3 = 1'b0;
        @(negedge clk);
        chk("done_width", 32'(done_s), 32'(0));
        chk("busy_after", 32'(busy_s), 32'(0));
        repeat (3) @(negedge clk);
        chk("busy_idle", 32'(busy_s), 32'(0));
        chk("pass_hold", 32'(pass_s), 32'(ep));
        chk("err_hold",  32'(err_s),  32'(ee));
        chk("fail_hold", 32'(fail_s), 32'(ef));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        bit hit;
        sel = 1'b0;
        rst1 = 1'b1; rst3 = 1'b1;
        start1 = 1'b0; start3 = 1'b0;
        mode1 = 0; mode3 = 0;
        repeat (2) @(negedge clk);
        chk("rst_vec",  32'({a1, b1, cin1}), 32'(0));
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_done", 32'(done1), 32'(0));
        chk("rst_pass", 32'(pass1), 32'(0));
        chk("rst_err",  32'(err1),  32'(0));
        chk("rst_fail", 32'(fail1), 32'(0));
        rst1 = 1'b0; rst3 = 1'b0;

        run(1'b0, 0, 1'b1, 4'd0, 8'h00, 1'b0);
        run(1'b0, 1, 1'b0, 4'd4, 8'h96, 1'b0);
        run(1'b0, 2, 1'b0, 4'd8, 8'hFF, 1'b0);
        d0 = ndone1;
        run(1'b0, 0, 1'b1, 4'd0, 8'h00, 1'b1);
        chk("hold_one_done", 32'(ndone1 - d0), 32'(1));
        run(1'b1, 0, 1'b1, 4'd0, 8'h00, 1'b0);
        run(1'b1, 1, 1'b0, 4'd4, 8'h96, 1'b0);

        // Reset mid-sweep at idx=3 on the SETTLE_CYCLES=1 instance.
        sel = 1'b0;
        mode1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk);
            start1 = 1'b0;
            hit = ({a1, b1, cin1} == 3'd3);
        end
        chk("reach_idx3", 32'(hit), 32'(1));
        d0 = ndone1;
        #2 rst1 = 1'b1;
        #1;
        chk("arst_vec",  32'({a1, b1, cin1}), 32'(0));
        chk("arst_busy", 32'(busy1), 32'(0));
        chk("arst_done", 32'(done1), 32'(0));
        chk("arst_pass", 32'(pass1), 32'(0));
        chk("arst_err",  32'(err1),  32'(0));
        chk("arst_fail", 32'(fail1), 32'(0));
        @(negedge clk);
        rst1 = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_rst", 32'(ndone1 - d0), 32'(0));
        chk("idle_after_rst",    32'(busy1), 32'(0));
        chk("vec_after_rst",     32'({a1, b1, cin1}), 32'(0));

        // Start on the first edge after reset release.
        rst1 = 1'b1;
        @(posedge clk);
        #2 rst1 = 1'b0;
        run(1'b0, 0, 1'b1, 4'd0, 8'h00, 1'b0);

        chk("q1_empty", 32'(q1.size()), 32'(0));
        chk("q3_empty", 32'(q3.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
